// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  pool_pkg
//  Shared types, constants and address helper for the 2x2 max-pool stages.
//  Rev 1.0 - initial release
// ============================================================================
package pool_pkg;

  // Pass sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } pool_state_t;

  // Pooling window edge and number of taps per window
  localparam int WIN  = 2;
  localparam int TAPS = 4;

  // Channel-major, row-major byte address into a square feature map
  function automatic logic [31:0] src_byte_addr(
    input logic [31:0] ch,
    input logic [31:0] y,
    input logic [31:0] x,
    input logic [31:0] dim
  );
    return ch * dim * dim + y * dim + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int8_relu_max.sv
`default_nettype none
// ============================================================================
//  int8_relu_max
//  Combinational signed max of a running accumulator and a new int8 byte.
//  Seeding the accumulator with 0 makes the running max a ReLU'd max.
//  Rev 1.0 - initial release
// ============================================================================
module int8_relu_max (
  input  logic signed [7:0] acc,
  input  logic signed [7:0] din,
  output logic signed [7:0] max_out
);

  // Signed compare; no arithmetic, so no overflow is possible
  assign max_out = (din > acc) ? din : acc;

endmodule
`default_nettype wire

// File: rtl/maxpool2x2_relu_32ch.sv
`default_nettype none
// ============================================================================
//  maxpool2x2_relu_32ch
//  Reads a conv feature map byte by byte, applies ReLU and 2x2/stride-2 max
//  pooling, and streams each pooled byte with its linear index over
//  valid/ready.
//  Rev 1.0 - initial release
// ============================================================================
module maxpool2x2_relu_32ch
  import pool_pkg::*;
#(
  parameter int IN_DIM  = 26,
  parameter int CH      = 32,
  parameter int SRC_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        src_en,
  output logic [31:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [12:0] out_idx
);

  localparam int OUT_DIM = IN_DIM / WIN;
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int DIM_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(OUT_DIM - 1);
  localparam logic [1:0]       LAT_LAST = 2'(SRC_LAT);
  localparam logic [1:0]       TAP_LAST = 2'(TAPS - 1);

  pool_state_t             state, state_nxt;
  logic [CH_W-1:0]         ch;
  logic [DIM_W-1:0]        r, c;
  logic [1:0]              tap;
  logic [1:0]              lat_cnt;
  logic signed [7:0]       max_reg, max_nxt;
  logic                    last_win;
  logic [31:0]             tap_y, tap_x;

  assign last_win = (ch == CH_LAST) && (r == DIM_LAST) && (c == DIM_LAST);

  // Tap row/col inside the window: tap[1] picks the row, tap[0] the column
  assign tap_y = 32'({r, tap[1]});
  assign tap_x = 32'({c, tap[0]});

  assign src_addr = (state == RD) ?
                    src_byte_addr(32'(ch), tap_y, tap_x, 32'(IN_DIM)) : '0;

  assign out_data = (state == EMIT) ? max_reg : '0;
  assign out_idx  = (state == EMIT) ?
                    13'(32'(ch) * 32'(OUT_DIM * OUT_DIM) +
                        32'(r) * 32'(OUT_DIM) + 32'(c)) : '0;

  int8_relu_max u_max (
    .acc     (max_reg),
    .din     (src_data),
    .max_out (max_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    src_en    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RD;
      RD: begin
        busy   = 1'b1;
        src_en = 1'b1;
        if (lat_cnt == LAT_LAST && tap == TAP_LAST) state_nxt = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_win ? DONE : RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters, read latency counter and running max
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch      <= '0;
      r       <= '0;
      c       <= '0;
      tap     <= '0;
      lat_cnt <= '0;
      max_reg <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ch      <= '0;
          r       <= '0;
          c       <= '0;
          tap     <= '0;
          lat_cnt <= '0;
          max_reg <= '0;
        end
        RD: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            tap     <= tap + 2'd1;
            max_reg <= max_nxt;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        EMIT: if (out_ready && !last_win) begin
          max_reg <= '0;
          tap     <= '0;
          if (c == DIM_LAST) begin
            c <= '0;
            if (r == DIM_LAST) begin
              r  <= '0;
              ch <= ch + 1'b1;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_relu_32ch.sv
`default_nettype none
// ============================================================================
//  tb_maxpool2x2_relu_32ch
//  Directed bench: a default-size instance (SRC_LAT=1) and a small
//  SRC_LAT=3 instance, each fed by a delayed source-map model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_maxpool2x2_relu_32ch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, out_ready;
  logic sel;          // 0: default instance, 1: small SRC_LAT=3 instance
  int   mode;         // source pattern
  int   dim_s, total_s, ivl_s;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  logic [7:0] cap_data [0:3];

  // Instance A (defaults)
  logic        a_busy, a_done, a_src_en, a_valid;
  logic [31:0] a_addr, a_d1;
  logic [7:0]  a_src_data, a_data;
  logic [12:0] a_idx;
  logic        a_start;
  // Instance B (6x6x2, SRC_LAT=3)
  logic        b_busy, b_done, b_src_en, b_valid;
  logic [31:0] b_addr, b_d1, b_d2, b_d3;
  logic [7:0]  b_src_data, b_data;
  logic [12:0] b_idx;
  logic        b_start;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  maxpool2x2_relu_32ch #(.IN_DIM(26), .CH(32), .SRC_LAT(1)) u_dut_a (
    .clk(clk), .resetn(resetn), .start(a_start), .busy(a_busy), .done(a_done),
    .src_en(a_src_en), .src_addr(a_addr), .src_data(a_src_data),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_idx(a_idx)
  );

  maxpool2x2_relu_32ch #(.IN_DIM(6), .CH(2), .SRC_LAT(3)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .done(b_done),
    .src_en(b_src_en), .src_addr(b_addr), .src_data(b_src_data),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_idx(b_idx)
  );

  // Source map contents per pattern
  function automatic logic [7:0] src_byte(input logic [31:0] addr, input int md);
    logic [31:0] t;
    case (md)
      1: t = 32'hFB;
      2: case (addr)
           32'd0:  t = 32'h80;
           32'd1:  t = 32'h7F;
           32'd26: t = 32'h03;
           32'd27: t = 32'hFF;
           32'd2:  t = 32'hFF;
           32'd3:  t = 32'hFE;
           32'd28: t = 32'hFD;
           32'd29: t = 32'hFC;
           default: t = '0;
         endcase
      3: t = addr * 32'd37;
      default: t = addr;
    endcase
    return t[7:0];
  endfunction

  // Read-port latency model: data appears SRC_LAT cycles after the address
  always @(posedge clk) begin
    a_d1 <= a_addr;
    b_d1 <= b_addr;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign a_src_data = src_byte(a_d1, mode);
  assign b_src_data = src_byte(b_d3, mode);

  logic        busy_m, done_m, valid_m;
  logic [7:0]  data_m;
  logic [12:0] idx_m;
  assign busy_m  = sel ? b_busy  : a_busy;
  assign done_m  = sel ? b_done  : a_done;
  assign valid_m = sel ? b_valid : a_valid;
  assign data_m  = sel ? b_data  : a_data;
  assign idx_m   = sel ? b_idx   : a_idx;

  // Reference: max(0, window) for output index idx
  function automatic logic [7:0] exp_val(input int idx, input int dim, input int md);
    int od, ch, r, c, y, x;
    logic signed [7:0] m, v;
    od = dim / 2;
    ch = idx / (od * od);
    r  = (idx % (od * od)) / od;
    c  = idx % od;
    m  = '0;
    for (int t = 0; t < 4; t++) begin
      y = 2 * r + t / 2;
      x = 2 * c + t % 2;
      v = src_byte(32'(ch * dim * dim + y * dim + x), md);
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic select_dut(input logic s);
    sel     = s;
    dim_s   = s ? 6 : 26;
    total_s = s ? 18 : 5408;
    ivl_s   = s ? 17 : 9;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Runs one pass; n_stop>0 stops after that many transfers
  task automatic run_stream(input int n_stop, input bit bp, input bit poke, input bit full);
    int xf = 0, cyc = 0, last_cyc = 0, lows = 7, budget;
    bit hold = 0, fin = 0, last_seen = 0, poked = 0;
    logic [7:0]  h_data;
    logic [12:0] h_idx;
    budget = total_s * (ivl_s + 8) + 100;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total_cnt++;
    if (busy_m !== 1'b1) begin
      bad_cnt++; $display("FAIL busy_after_start got=%b want=1", busy_m);
    end
    while (!fin && cyc < budget) begin
      start = 1'b0;
      if (last_seen) begin
        total_cnt++;
        if ({done_m, busy_m, valid_m} !== 3'b100) begin
          bad_cnt++;
          $display("FAIL done_after_last got done/busy/valid=%b want=100", {done_m, busy_m, valid_m});
        end
        fin = 1;
      end else begin
        if (hold) begin
          total_cnt++;
          if (valid_m !== 1'b1 || data_m !== h_data || idx_m !== h_idx) begin
            bad_cnt++;
            $display("FAIL stall_stable got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                     valid_m, data_m, idx_m, h_data, h_idx);
          end
        end
        if (bp && lows > 0 && (valid_m === 1'b1 || $urandom_range(0, 1) == 1)) begin
          out_ready = 1'b0;
          lows--;
        end else begin
          out_ready = 1'b1;
        end
        if (poke && !poked && xf == 50) begin
          start = 1'b1;
          poked = 1;
        end
        if (valid_m === 1'b1 && out_ready) begin
          total_cnt++;
          if (idx_m !== 13'(xf) || data_m !== exp_val(xf, dim_s, mode) || done_m !== 1'b0) begin
            bad_cnt++;
            $display("FAIL xfer got idx=%0d data=%0d done=%b want idx=%0d data=%0d done=0",
                     idx_m, data_m, done_m, xf, exp_val(xf, dim_s, mode));
          end
          if (full && !bp && xf > 0) begin
            total_cnt++;
            if (cyc - last_cyc != ivl_s) begin
              bad_cnt++;
              $display("FAIL interval got=%0d want=%0d at idx %0d", cyc - last_cyc, ivl_s, xf);
            end
          end
          if (xf < 4) cap_data[xf] = data_m;
          last_cyc = cyc;
          xf++;
          lows = 7;
          hold = 0;
          if (xf == total_s) last_seen = 1;
          if (n_stop > 0 && xf == n_stop) fin = 1;
        end else begin
          hold   = valid_m;
          h_data = data_m;
          h_idx  = idx_m;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      total_cnt++; bad_cnt++;
      $display("FAIL stream_timeout got xfers=%0d want=%0d", xf, (n_stop > 0) ? n_stop : total_s);
    end else if (full) begin
      total_cnt++;
      if (xf != total_s || done_m !== 1'b0 || busy_m !== 1'b0) begin
        bad_cnt++;
        $display("FAIL pass_end got count=%0d done=%b busy=%b want count=%0d done=0 busy=0",
                 xf, done_m, busy_m, total_s);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; out_ready = 1'b0; mode = 0;
    select_dut(1'b0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({a_busy, a_done, a_src_en, a_valid, a_addr, a_data, a_idx} !== '0) begin
      bad_cnt++; $display("FAIL reset_a got addr=%0d idx=%0d want all 0", a_addr, a_idx);
    end
    total_cnt++;
    if ({b_busy, b_done, b_src_en, b_valid, b_addr, b_data, b_idx} !== '0) begin
      bad_cnt++; $display("FAIL reset_b got addr=%0d idx=%0d want all 0", b_addr, b_idx);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({a_busy, a_valid, a_src_en} !== 3'b000) begin
      bad_cnt++; $display("FAIL idle_no_start got=%b want=000", {a_busy, a_valid, a_src_en});
    end
  endtask

  task automatic test_ramp();
    select_dut(1'b0); mode = 0;
    run_stream(0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_negative_abort();
    select_dut(1'b0); mode = 1;
    run_stream(1001, 1'b0, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    total_cnt++;
    if ({a_busy, a_done, a_src_en, a_valid, a_addr, a_data, a_idx} !== '0) begin
      bad_cnt++; $display("FAIL abort_reset got busy=%b addr=%0d want all 0", a_busy, a_addr);
    end
    @(posedge clk); #1;
    total_cnt++;
    if ({a_busy, a_done, a_src_en, a_valid, a_addr, a_data, a_idx} !== '0) begin
      bad_cnt++; $display("FAIL abort_edge got busy=%b done=%b want 0", a_busy, a_done);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_window();
    select_dut(1'b0); mode = 2;
    run_stream(3, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (cap_data[0] !== 8'd127) begin
      bad_cnt++; $display("FAIL window_mixed got=%0d want=127", cap_data[0]);
    end
    total_cnt++;
    if (cap_data[1] !== 8'd0) begin
      bad_cnt++; $display("FAIL window_neg got=%0d want=0", cap_data[1]);
    end
    pulse_reset();
  endtask

  task automatic test_backpressure();
    select_dut(1'b0); mode = 0;
    run_stream(300, 1'b1, 1'b0, 1'b0);
    pulse_reset();
  endtask

  task automatic test_lat3();
    select_dut(1'b1); mode = 0;
    run_stream(0, 1'b0, 1'b0, 1'b1);
    mode = 3;
    run_stream(0, 1'b0, 1'b0, 1'b1);
    run_stream(0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative_abort();
    test_window();
    test_backpressure();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
